// File: rtl/alu_issue_decoder_pkg.sv
// Shared encodings and the decoded-instruction bundle for the ALU issue decoder.
// Opcode/funct values follow the MIPS32 integer encoding.
package alu_issue_decoder_pkg;

   localparam int XLEN    = 32;
   localparam int ALU_OPS = 12;

   // One-hot bit positions inside alu_control, add in the MSB down to lui in the LSB
   localparam int ALU_OP_ADD  = 11;
   localparam int ALU_OP_SUB  = 10;
   localparam int ALU_OP_SLT  = 9;
   localparam int ALU_OP_SLTU = 8;
   localparam int ALU_OP_AND  = 7;
   localparam int ALU_OP_NOR  = 6;
   localparam int ALU_OP_OR   = 5;
   localparam int ALU_OP_XOR  = 4;
   localparam int ALU_OP_SLL  = 3;
   localparam int ALU_OP_SRL  = 2;
   localparam int ALU_OP_SRA  = 1;
   localparam int ALU_OP_LUI  = 0;

   typedef enum logic [5:0] {
      OP_RTYPE = 6'h00,
      OP_ADDI  = 6'h08,
      OP_ADDIU = 6'h09,
      OP_SLTI  = 6'h0A,
      OP_SLTIU = 6'h0B,
      OP_ANDI  = 6'h0C,
      OP_ORI   = 6'h0D,
      OP_XORI  = 6'h0E,
      OP_LUI   = 6'h0F
   } opcode_e;

   typedef enum logic [5:0] {
      FN_SLL  = 6'h00,
      FN_SRL  = 6'h02,
      FN_SRA  = 6'h03,
      FN_SLLV = 6'h04,
      FN_SRLV = 6'h06,
      FN_SRAV = 6'h07,
      FN_ADD  = 6'h20,
      FN_ADDU = 6'h21,
      FN_SUB  = 6'h22,
      FN_SUBU = 6'h23,
      FN_AND  = 6'h24,
      FN_OR   = 6'h25,
      FN_XOR  = 6'h26,
      FN_NOR  = 6'h27,
      FN_SLT  = 6'h2A,
      FN_SLTU = 6'h2B
   } funct_e;

   typedef struct packed {
      logic [ALU_OPS-1:0] alu_control;
      logic [XLEN-1:0]    src1;
      logic [XLEN-1:0]    src2;
      logic [4:0]         dest;
      logic               rf_we;
      logic               ovf_chk;
      logic               illegal;
   } dec_t;

endpackage

// File: rtl/alu_issue_decoder_if.sv
// Fetch-side, regfile-read and execute-side signals of the ALU issue decoder.
// The decoder uses the slave view; whatever drives fetch and consumes execute uses master.
interface alu_issue_decoder_if;
   import alu_issue_decoder_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic [XLEN-1:0]     in_pc;
   logic [XLEN-1:0]     in_inst;
   logic [4:0]          rf_raddr1;
   logic [4:0]          rf_raddr2;
   logic [XLEN-1:0]     rf_rdata1;
   logic [XLEN-1:0]     rf_rdata2;
   logic                out_valid;
   logic                out_ready;
   logic [XLEN-1:0]     out_pc;
   logic [ALU_OPS-1:0]  out_alu_control;
   logic [XLEN-1:0]     out_alu_src1;
   logic [XLEN-1:0]     out_alu_src2;
   logic [4:0]          out_dest;
   logic                out_rf_we;
   logic                out_ovf_chk;
   logic                out_illegal;

   modport slave (
      input  in_valid, in_pc, in_inst, rf_rdata1, rf_rdata2, out_ready,
      output in_ready, rf_raddr1, rf_raddr2, out_valid, out_pc, out_alu_control,
             out_alu_src1, out_alu_src2, out_dest, out_rf_we, out_ovf_chk, out_illegal
   );

   modport master (
      output in_valid, in_pc, in_inst, rf_rdata1, rf_rdata2, out_ready,
      input  in_ready, rf_raddr1, rf_raddr2, out_valid, out_pc, out_alu_control,
             out_alu_src1, out_alu_src2, out_dest, out_rf_we, out_ovf_chk, out_illegal
   );

endinterface

// File: rtl/alu_issue_dec_comb.sv
// Purely combinational decode of one instruction word plus its regfile read data
// into the ALU control/operand bundle; illegal encodings collapse to an all-zero bundle.
module alu_issue_dec_comb
   import alu_issue_decoder_pkg::*;
(
   input  logic [XLEN-1:0] inst,
   input  logic [XLEN-1:0] rdata1,
   input  logic [XLEN-1:0] rdata2,
   output logic [4:0]      raddr1,
   output logic [4:0]      raddr2,
   output dec_t            dec
);

   logic [5:0]         opcode;
   logic [5:0]         funct;
   logic [4:0]         rd;
   logic [4:0]         shamt;
   logic [15:0]        imm;
   logic               legal;
   logic               ovf;
   logic [ALU_OPS-1:0] ctrl;
   logic [XLEN-1:0]    src1;
   logic [XLEN-1:0]    src2;
   logic [4:0]         dest;

   assign opcode = inst[31:26];
   assign raddr1 = inst[25:21];
   assign raddr2 = inst[20:16];
   assign rd     = inst[15:11];
   assign shamt  = inst[10:6];
   assign funct  = inst[5:0];
   assign imm    = inst[15:0];

   always_comb begin
      legal = 1'b1;
      ovf   = 1'b0;
      ctrl  = '0;
      src1  = rdata1;
      src2  = rdata2;
      dest  = rd;
      dec   = '0;
      if (opcode == OP_RTYPE) begin
         case (funct)
            FN_ADD:  begin ctrl[ALU_OP_ADD] = 1'b1; ovf = 1'b1; end
            FN_ADDU: ctrl[ALU_OP_ADD]  = 1'b1;
            FN_SUB:  begin ctrl[ALU_OP_SUB] = 1'b1; ovf = 1'b1; end
            FN_SUBU: ctrl[ALU_OP_SUB]  = 1'b1;
            FN_SLT:  ctrl[ALU_OP_SLT]  = 1'b1;
            FN_SLTU: ctrl[ALU_OP_SLTU] = 1'b1;
            FN_AND:  ctrl[ALU_OP_AND]  = 1'b1;
            FN_OR:   ctrl[ALU_OP_OR]   = 1'b1;
            FN_XOR:  ctrl[ALU_OP_XOR]  = 1'b1;
            FN_NOR:  ctrl[ALU_OP_NOR]  = 1'b1;
            FN_SLL:  begin ctrl[ALU_OP_SLL] = 1'b1; src1 = {27'b0, shamt}; end
            FN_SRL:  begin ctrl[ALU_OP_SRL] = 1'b1; src1 = {27'b0, shamt}; end
            FN_SRA:  begin ctrl[ALU_OP_SRA] = 1'b1; src1 = {27'b0, shamt}; end
            FN_SLLV: ctrl[ALU_OP_SLL]  = 1'b1;
            FN_SRLV: ctrl[ALU_OP_SRL]  = 1'b1;
            FN_SRAV: ctrl[ALU_OP_SRA]  = 1'b1;
            default: legal = 1'b0;
         endcase
         // The shamt field is only meaningful for shifts; anything else must leave it zero
         if (funct[5] && (shamt != 5'd0)) begin
            legal = 1'b0;
         end
      end else begin
         dest = raddr2;
         src2 = {{16{imm[15]}}, imm};
         case (opcode)
            OP_ADDI:  begin ctrl[ALU_OP_ADD] = 1'b1; ovf = 1'b1; end
            OP_ADDIU: ctrl[ALU_OP_ADD]  = 1'b1;
            OP_SLTI:  ctrl[ALU_OP_SLT]  = 1'b1;
            OP_SLTIU: ctrl[ALU_OP_SLTU] = 1'b1;
            OP_ANDI:  begin ctrl[ALU_OP_AND] = 1'b1; src2 = {16'b0, imm}; end
            OP_ORI:   begin ctrl[ALU_OP_OR]  = 1'b1; src2 = {16'b0, imm}; end
            OP_XORI:  begin ctrl[ALU_OP_XOR] = 1'b1; src2 = {16'b0, imm}; end
            OP_LUI:   begin ctrl[ALU_OP_LUI] = 1'b1; src2 = {16'b0, imm}; src1 = '0; end
            default:  legal = 1'b0;
         endcase
      end
      if (legal) begin
         dec.alu_control = ctrl;
         dec.src1        = src1;
         dec.src2        = src2;
         dec.dest        = dest;
         dec.rf_we       = (dest != 5'd0);
         dec.ovf_chk     = ovf;
      end else begin
         dec.illegal     = 1'b1;
      end
   end

endmodule

// File: rtl/alu_issue_decoder.sv
// Decode stage in front of the ALU: one-entry pipeline register with a valid/ready
// handshake on both sides, fed by the combinational decoder.
module alu_issue_decoder
   import alu_issue_decoder_pkg::*;
(
   input  logic                clk,
   input  logic                resetn,
   input  logic                flush,
   alu_issue_decoder_if.slave  bus
);

   dec_t            dec_next;
   dec_t            dec_q;
   logic [XLEN-1:0] pc_q;
   logic            valid_q;
   logic            accept;

   alu_issue_dec_comb u_dec (
      .inst   (bus.in_inst),
      .rdata1 (bus.rf_rdata1),
      .rdata2 (bus.rf_rdata2),
      .raddr1 (bus.rf_raddr1),
      .raddr2 (bus.rf_raddr2),
      .dec    (dec_next)
   );

   assign bus.in_ready = ~valid_q | bus.out_ready;
   assign accept       = bus.in_valid & bus.in_ready;

   // Flush wins over a same-cycle accept so a squashed instruction never reaches execute
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         dec_q   <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         valid_q <= 1'b1;
         pc_q    <= bus.in_pc;
         dec_q   <= dec_next;
      end else if (bus.out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign bus.out_valid       = valid_q;
   assign bus.out_pc          = pc_q;
   assign bus.out_alu_control = dec_q.alu_control;
   assign bus.out_alu_src1    = dec_q.src1;
   assign bus.out_alu_src2    = dec_q.src2;
   assign bus.out_dest        = dec_q.dest;
   assign bus.out_rf_we       = dec_q.rf_we;
   assign bus.out_ovf_chk     = dec_q.ovf_chk;
   assign bus.out_illegal     = dec_q.illegal;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Scoreboard bench for alu_issue_decoder: a reference decode is queued on each accepted
// instruction and compared against the registered payload while it is presented.
module tb_alu_issue_decoder;
   import alu_issue_decoder_pkg::*;

   typedef struct {
      logic [31:0] pc;
      logic [11:0] ctrl;
      logic [31:0] src1;
      logic [31:0] src2;
      logic [4:0]  dest;
      logic        we;
      logic        ovf;
      logic        ill;
   } exp_t;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   logic flush  = 1'b0;
   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   alu_issue_decoder_if bus ();

   alu_issue_decoder dut (
      .clk    (clk),
      .resetn (resetn),
      .flush  (flush),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Reference decode: pick the one-hot position, then shape operands around it
   function automatic exp_t refModel(input logic [31:0] inst, input logic [31:0] rd1,
                                     input logic [31:0] rd2, input logic [31:0] pc);
      exp_t e;
      int   idx;
      logic [5:0] op;
      logic [5:0] fn;
      logic [4:0] sh;
      op = inst[31:26];
      fn = inst[5:0];
      sh = inst[10:6];
      idx = -1;
      e.pc = pc; e.ovf = 1'b0; e.src1 = rd1;
      if (op == 6'h00) begin
         e.src2 = rd2; e.dest = inst[15:11];
         case (fn)
            6'h20: begin idx = 11; e.ovf = 1'b1; end
            6'h21: idx = 11;
            6'h22: begin idx = 10; e.ovf = 1'b1; end
            6'h23: idx = 10;
            6'h2A: idx = 9;
            6'h2B: idx = 8;
            6'h24: idx = 7;
            6'h27: idx = 6;
            6'h25: idx = 5;
            6'h26: idx = 4;
            6'h00: begin idx = 3; e.src1 = {27'b0, sh}; end
            6'h02: begin idx = 2; e.src1 = {27'b0, sh}; end
            6'h03: begin idx = 1; e.src1 = {27'b0, sh}; end
            6'h04: idx = 3;
            6'h06: idx = 2;
            6'h07: idx = 1;
            default: idx = -1;
         endcase
         if (idx >= 4 && sh != 5'd0) idx = -1;
      end else begin
         e.src2 = {{16{inst[15]}}, inst[15:0]}; e.dest = inst[20:16];
         case (op)
            6'h08: begin idx = 11; e.ovf = 1'b1; end
            6'h09: idx = 11;
            6'h0A: idx = 9;
            6'h0B: idx = 8;
            6'h0C: begin idx = 7; e.src2 = {16'b0, inst[15:0]}; end
            6'h0D: begin idx = 5; e.src2 = {16'b0, inst[15:0]}; end
            6'h0E: begin idx = 4; e.src2 = {16'b0, inst[15:0]}; end
            6'h0F: begin idx = 0; e.src2 = {16'b0, inst[15:0]}; e.src1 = '0; end
            default: idx = -1;
         endcase
      end
      if (idx < 0) begin
         e.ctrl = '0; e.src1 = '0; e.src2 = '0; e.dest = '0;
         e.we = 1'b0; e.ovf = 1'b0; e.ill = 1'b1;
      end else begin
         e.ctrl = 12'b1 << idx;
         e.we   = (e.dest != 5'd0);
         e.ill  = 1'b0;
      end
      return e;
   endfunction

   task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                                input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic ordy, input logic fl);
      logic exp_ready;
      @(negedge clk);
      checkOutput("out_valid", {31'b0, bus.out_valid}, {31'b0, (sb.size() != 0)});
      if (sb.size() != 0 && bus.out_valid) begin
         checkOutput("out_pc",   bus.out_pc, sb[0].pc);
         checkOutput("out_ctrl", {20'b0, bus.out_alu_control}, {20'b0, sb[0].ctrl});
         checkOutput("out_src1", bus.out_alu_src1, sb[0].src1);
         checkOutput("out_src2", bus.out_alu_src2, sb[0].src2);
         checkOutput("out_dest", {27'b0, bus.out_dest}, {27'b0, sb[0].dest});
         checkOutput("out_we",   {31'b0, bus.out_rf_we}, {31'b0, sb[0].we});
         checkOutput("out_ovf",  {31'b0, bus.out_ovf_chk}, {31'b0, sb[0].ovf});
         checkOutput("out_ill",  {31'b0, bus.out_illegal}, {31'b0, sb[0].ill});
      end
      bus.in_valid  = v;
      bus.in_inst   = inst;
      bus.in_pc     = pc;
      bus.rf_rdata1 = rd1;
      bus.rf_rdata2 = rd2;
      bus.out_ready = ordy;
      flush         = fl;
      #1;
      exp_ready = (sb.size() == 0) || ordy;
      checkOutput("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_ready});
      checkOutput("raddr1", {27'b0, bus.rf_raddr1}, {27'b0, inst[25:21]});
      checkOutput("raddr2", {27'b0, bus.rf_raddr2}, {27'b0, inst[20:16]});
      if (fl) begin
         sb.delete();
      end else begin
         if (sb.size() != 0 && ordy) void'(sb.pop_front());
         if (v && exp_ready) sb.push_back(refModel(inst, rd1, rd2, pc));
      end
   endtask

   function automatic logic [31:0] randInst();
      logic [5:0] ops [10];
      logic [5:0] fns [18];
      logic [31:0] r;
      ops = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
      fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h2B, 6'h24, 6'h25, 6'h26,
              6'h27, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h01, 6'h3F};
      r = $urandom;
      if ($urandom_range(0, 9) == 0) begin
         r[31:26] = 6'h23;
      end else begin
         r[31:26] = ops[$urandom_range(0, 9)];
      end
      if (r[31:26] == 6'h00) begin
         r[5:0] = fns[$urandom_range(0, 17)];
         if ($urandom_range(0, 3) != 0 && r[5]) r[10:6] = 5'd0;
      end
      return r;
   endfunction

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_inst   = '0;
      bus.in_pc     = '0;
      bus.rf_rdata1 = '0;
      bus.rf_rdata2 = '0;
      bus.out_ready = 1'b0;

      @(negedge clk);
      checkOutput("rst_valid", {31'b0, bus.out_valid}, 32'd0);
      checkOutput("rst_pc",    bus.out_pc, 32'd0);
      checkOutput("rst_ctrl",  {20'b0, bus.out_alu_control}, 32'd0);
      checkOutput("rst_src1",  bus.out_alu_src1, 32'd0);
      checkOutput("rst_ill",   {31'b0, bus.out_illegal}, 32'd0);
      resetn = 1'b1;

      applyStimulus(1'b1, 32'h2422FFFF, 32'h100, 32'd5, 32'd0, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h00041940, 32'h104, 32'd0, 32'h0F, 1'b1, 1'b0);
      checkOutput("t1_ctrl", {20'b0, bus.out_alu_control}, 32'h800);
      checkOutput("t1_src2", bus.out_alu_src2, 32'hFFFFFFFF);
      checkOutput("t1_dest", {27'b0, bus.out_dest}, 32'd2);
      applyStimulus(1'b1, 32'h3C051234, 32'h108, 32'h55, 32'h66, 1'b1, 1'b0);
      checkOutput("t2_ctrl", {20'b0, bus.out_alu_control}, 32'h008);
      checkOutput("t2_src1", bus.out_alu_src1, 32'd5);
      applyStimulus(1'b1, 32'h34068000, 32'h10C, 32'd0, 32'd0, 1'b1, 1'b0);
      checkOutput("t3_ctrl", {20'b0, bus.out_alu_control}, 32'h001);
      checkOutput("t3_src2", bus.out_alu_src2, 32'h00001234);
      applyStimulus(1'b1, 32'hFC000000, 32'h110, 32'd1, 32'd2, 1'b1, 1'b0);
      checkOutput("t3_ori",  bus.out_alu_src2, 32'h00008000);
      applyStimulus(1'b1, 32'h00000000, 32'h114, 32'd3, 32'd4, 1'b1, 1'b0);
      checkOutput("t4_ill",  {31'b0, bus.out_illegal}, 32'd1);
      checkOutput("t4_ctrl", {20'b0, bus.out_alu_control}, 32'd0);
      applyStimulus(1'b1, 32'h00223820, 32'h118, 32'h7FFFFFFF, 32'd1, 1'b1, 1'b0);
      checkOutput("t4_nop",  {20'b0, bus.out_alu_control}, 32'h008);
      checkOutput("t4_nopwe", {31'b0, bus.out_rf_we}, 32'd0);

      // Mixed legal/illegal encodings including shamt abuse and a write to $0
      applyStimulus(1'b1, 32'h00223822, 32'h11C, 32'd9, 32'd4, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h0022382B, 32'h120, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h00223867, 32'h124, 32'd1, 32'd2, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h00041883, 32'h128, 32'd0, 32'h80000000, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h00221806, 32'h12C, 32'd3, 32'd8, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h00220021, 32'h130, 32'd1, 32'd1, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h2022FFF0, 32'h134, 32'd7, 32'd0, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h3022F0F0, 32'h138, 32'hFFFF, 32'd0, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h00223801, 32'h13C, 32'd1, 32'd1, 1'b1, 1'b0);

      // Back-pressure: hold the payload for three cycles while fetch keeps offering
      applyStimulus(1'b1, 32'h00A63824, 32'h200, 32'hF0F0, 32'h0FF0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'h28A7FFFF, 32'h204, 32'd3, 32'd0, 1'b0, 1'b0);
      end
      applyStimulus(1'b1, 32'h28A7FFFF, 32'h204, 32'd3, 32'd0, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);

      for (int i = 0; i < 60; i++) begin
         applyStimulus(($urandom_range(0, 3) != 0), randInst(), 32'h400 + i * 4,
                       $urandom, $urandom, ($urandom_range(0, 2) != 0), 1'b0);
      end

      // Flush while holding one instruction and accepting another
      applyStimulus(1'b1, 32'h00223820, 32'h500, 32'd1, 32'd2, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h00223822, 32'h504, 32'd1, 32'd2, 1'b1, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h24210001, 32'h508, 32'd8, 32'd0, 1'b0, 1'b0);

      // Asynchronous reset landing between clock edges
      @(posedge clk);
      #2;
      checkOutput("pre_rst_valid", {31'b0, bus.out_valid}, 32'd1);
      resetn = 1'b0;
      #1;
      checkOutput("async_rst_valid", {31'b0, bus.out_valid}, 32'd0);
      checkOutput("async_rst_pc", bus.out_pc, 32'd0);
      sb.delete();
      bus.in_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;

      applyStimulus(1'b1, 32'h3C0FABCD, 32'h600, 32'd0, 32'd0, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
